// File: rtl/wb_ram_arbiter.sv
// Two-master / one-slave Wishbone arbiter sharing the on-chip RAM between data (M0) and fetch (M1).
// Optional macro WB_ARB_ROUND_ROBIN_EN: ties go to the master that did not own the bus last.

package wb_arb_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
    logic        we;
    logic        stb;
    logic        cyc;
  } wb_m2s_t;

  typedef struct packed {
    logic [31:0] data;
    logic        ack;
  } wb_s2m_t;
endpackage

module wb_ram_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter int unsigned TCNT_W      = 5
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  wb_m2s_t     i_m0_m2s_wb,
  output wb_s2m_t     o_m0_s2m_wb,
  input  wb_m2s_t     i_m1_m2s_wb,
  output wb_s2m_t     o_m1_s2m_wb,
  output wb_m2s_t     o_s_m2s_wb,
  input  wb_s2m_t     i_s_s2m_wb,
  output logic [1:0]  o_grant,
  output logic        o_timeout
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_G0   = 2'b01,
    ST_G1   = 2'b10
  } state_t;

  localparam logic [TCNT_W-1:0] WDOG_LIMIT = TCNT_W'(TIMEOUT_CYC);
  localparam logic [TCNT_W-1:0] WDOG_MAX   = '1;
  localparam bit                WDOG_EN    = (TIMEOUT_CYC != 0);

  state_t            state_q, state_d;
  logic [TCNT_W-1:0] wdog_q, wdog_d;
  logic              last_q, last_d;   // 1 = M1 was the most recent owner
  logic              m0_req, m1_req, own_req, fire, tie_m1;

  assign m0_req = i_m0_m2s_wb.stb & i_m0_m2s_wb.cyc;
  assign m1_req = i_m1_m2s_wb.stb & i_m1_m2s_wb.cyc;

`ifdef WB_ARB_ROUND_ROBIN_EN
  assign tie_m1 = ~last_q;
`else
  assign tie_m1 = 1'b0;
`endif

  always_comb begin
    own_req = 1'b0;
    case (state_q)
      ST_G0:   own_req = m0_req;
      ST_G1:   own_req = m1_req;
      default: own_req = 1'b0;
    endcase
  end

  // A real ack in the would-be fire cycle wins over the watchdog.
  assign fire = WDOG_EN && own_req && (wdog_q == WDOG_LIMIT) && !i_s_s2m_wb.ack;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= ST_IDLE;
      wdog_q  <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      wdog_q  <= wdog_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (m0_req && m1_req) state_d = tie_m1 ? ST_G1 : ST_G0;
        else if (m0_req)      state_d = ST_G0;
        else if (m1_req)      state_d = ST_G1;
      end
      ST_G0: begin
        if (fire)                    state_d = ST_IDLE;
        else if (!i_m0_m2s_wb.cyc)   state_d = m1_req ? ST_G1 : ST_IDLE;
      end
      ST_G1: begin
        if (fire)                    state_d = ST_IDLE;
        else if (!i_m1_m2s_wb.cyc)   state_d = m0_req ? ST_G0 : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wdog_d = wdog_q;
    if (state_d != state_q || state_q == ST_IDLE || i_s_s2m_wb.ack) wdog_d = '0;
    else if (own_req && wdog_q != WDOG_MAX)                         wdog_d = wdog_q + 1'b1;
  end

  always_comb begin
    last_d = last_q;
    if (state_d == ST_G0 && state_q != ST_G0) last_d = 1'b0;
    if (state_d == ST_G1 && state_q != ST_G1) last_d = 1'b1;
  end

  always_comb begin
    o_s_m2s_wb  = '0;
    o_m0_s2m_wb = '0;
    o_m1_s2m_wb = '0;
    case (state_q)
      ST_G0: begin
        o_s_m2s_wb  = i_m0_m2s_wb;
        o_m0_s2m_wb = i_s_s2m_wb;
        if (fire) begin
          o_s_m2s_wb.stb  = 1'b0;
          o_s_m2s_wb.cyc  = 1'b0;
          o_m0_s2m_wb.data = '0;
          o_m0_s2m_wb.ack  = 1'b1;
        end
      end
      ST_G1: begin
        o_s_m2s_wb  = i_m1_m2s_wb;
        o_m1_s2m_wb = i_s_s2m_wb;
        if (fire) begin
          o_s_m2s_wb.stb  = 1'b0;
          o_s_m2s_wb.cyc  = 1'b0;
          o_m1_s2m_wb.data = '0;
          o_m1_s2m_wb.ack  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign o_grant   = {state_q == ST_G1, state_q == ST_G0};
  assign o_timeout = fire;

endmodule
